uart_tx_avalon: RTL and testbench
=================================

// Module: uart_tx_avalon
// PURPOSE
//  Avalon-MM slave UART transmitter: CPU writes bytes into a 4-deep FIFO, block serialises them 8N1 (optional parity) on TX_out.
//  Transmit-side counterpart of the SoC UART receiver peripheral; same bus interface style, same baud and frame format.
//  Sits on the system interconnect; TX_out goes straight to the board pin.
// PARAMETERS
//  CLKS_PER_BIT  434  clk cycles per serial bit (50 MHz / 115200)
//  DATA_BITS     8    data bits per frame, LSB first
//  FIFO_DEPTH    4    TX FIFO entries (power of 2)
// PORTS
//  clk         in   1   system clock; single clock domain
//  reset_n     in   1   asynchronous, active-low reset
//  address     in   2   register word address
//  read        in   1   bus read strobe
//  write       in   1   bus write strobe
//  chipselect  in   1   slave select; read/write ignored when low
//  writedata   in   32  bus write data
//  readdata    out  32  bus read data, registered
//  TX_out      out  1   serial line, idle high
// BEHAVIOUR
//  Register map (access only when chipselect=1):
//   0 W  TXDATA: push writedata[DATA_BITS-1:0] into FIFO. Read returns 0.
//   1 R  STATUS: [0] busy (FSM not IDLE), [1] empty, [2] full, [3] overflow (sticky), [7:4] FIFO count. Writes ignored.
//   2 RW CONTROL: [0] parity_en, [1] parity_odd; write [2]=1 clears overflow (self-clearing, reads 0).
//   3    reserved: reads 0, writes ignored.
//  readdata: loaded on the clk edge where chipselect&read (1-cycle read latency); holds value otherwise.
//  Reset: readdata=0, TX_out=1, FIFO empty, CONTROL=0, overflow=0, FSM=IDLE, baud counter=0.
//  FIFO push accepted when !full OR a pop happens the same cycle; rejected push sets overflow, data dropped, FIFO unchanged.
//  Simultaneous push+pop with count 0 is impossible (pop requires !empty); with count 0 < n < DEPTH, count unchanged.
//  Pointers wrap modulo FIFO_DEPTH; count is 0..FIFO_DEPTH inclusive.
//  FSM: IDLE, START, DATA, PARITY, STOP.
//   IDLE: TX_out=1. If !empty: pop head into shift reg, latch parity_en/parity_odd, clear baud cnt -> START.
//   START: TX_out=0 for CLKS_PER_BIT cycles -> DATA.
//   DATA: TX_out=shift[0], shift right each bit; after DATA_BITS bits -> PARITY if latched parity_en else STOP.
//   PARITY: TX_out = ^data XOR parity_odd (even parity when parity_odd=0), one bit time -> STOP.
//   STOP: TX_out=1 for one bit time -> IDLE; back-to-back frames: next START follows after exactly one IDLE cycle.
//  Baud counter counts 0..CLKS_PER_BIT-1; bit boundary on terminal count; every bit is exactly CLKS_PER_BIT cycles.
//  TX_out is driven from a register (no glitches); first START-bit low appears 1 cycle after the IDLE pop edge.
//  CONTROL writes mid-frame affect only the next frame.
//  Reset mid-frame: line returns high immediately, FIFO contents discarded, frame aborted.
//  Frame length: (2 + DATA_BITS + parity_en) * CLKS_PER_BIT + 1 cycles including IDLE turnaround.
// STRUCTURE
//  Shared package: register address constants (ADDR_TXDATA=0, ADDR_STATUS=1, ADDR_CONTROL=2), STATUS/CONTROL bit indices, FSM state encoding.
//  Sub-module uart_tx_core: baud counter + FSM + shift reg; inputs start/data/parity cfg, outputs TX_out/busy/pop.
//  Top holds bus decode, FIFO, CONTROL/overflow registers, readdata register.
// TESTING (sim with CLKS_PER_BIT=4)
//  Write 0x55 to addr 0, parity off -> TX_out: 0,1,0,1,0,1,0,1,0,1 each 4 cycles, then idle 1; STATUS busy=1 during frame, then 0x02.
//  CONTROL=0x1, write 0x07 -> parity bit 1 after data (three 1s, even); CONTROL=0x3 same byte -> parity bit 0.
//  Five back-to-back writes 0x01..0x05 while idle -> first popped, 4 queued, 6th write sets STATUS[3]; all five frames emitted in order, no gap > 1 cycle.
//  Write addr 2 with 0x4 after overflow -> STATUS[3]=0; addr 3 read -> 0; read of addr 1 returns value one cycle after strobe.
//  Assert reset_n low mid DATA bit 3 of 0xA5 with 2 queued -> TX_out=1 immediately, STATUS=0x02 after release, no further frames.
//  Read/write with chipselect=0 -> no FIFO push, readdata unchanged.

Source files
------------

// File: rtl/uart_tx_avalon_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_tx_avalon_pkg: register map, bit indices and FSM encoding. Rev 1.0
// ---------------------------------------------------------------------------
package uart_tx_avalon_pkg;

  localparam logic [1:0] ADDR_TXDATA  = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;

  localparam int ST_BUSY    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_FULL    = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 4;

  localparam int CTL_PAR_EN  = 0;
  localparam int CTL_PAR_ODD = 1;
  localparam int CTL_OVF_CLR = 2;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_core.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_tx_core: baud counter, frame FSM and shift register. Rev 1.0
// ---------------------------------------------------------------------------
module uart_tx_core
  import uart_tx_avalon_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  output logic                 tx,
  output logic                 busy,
  output logic                 pop
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DATA_BITS - 1);

  tx_state_t            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_en_q, par_en_d;
  logic                 par_bit_q, par_bit_d;
  logic                 tx_q, tx_d;
  logic                 bit_end;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= TX_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    pop       = 1'b0;
    bit_end   = (cnt_q == CNT_MAX);
    cnt_d     = bit_end ? '0 : cnt_q + 1'b1;
    case (state_q)
      TX_IDLE: begin
        cnt_d = '0;
        if (start) begin
          pop       = 1'b1;
          shift_d   = data;
          par_en_d  = parity_en;
          par_bit_d = (^data) ^ parity_odd;
          idx_d     = '0;
          state_d   = TX_START;
        end
      end
      TX_START:  if (bit_end) state_d = TX_DATA;
      TX_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 1'b1;
          if (idx_q == IDX_MAX) state_d = par_en_q ? TX_PARITY : TX_STOP;
        end
      end
      TX_PARITY: if (bit_end) state_d = TX_STOP;
      TX_STOP:   if (bit_end) state_d = TX_IDLE;
      default:   state_d = TX_IDLE;
    endcase

    // Line level follows the next state so the pin is a clean register output.
    case (state_d)
      TX_START:  tx_d = 1'b0;
      TX_DATA:   tx_d = shift_d[0];
      TX_PARITY: tx_d = par_bit_d;
      default:   tx_d = 1'b1;
    endcase
  end

  assign tx   = tx_q;
  assign busy = (state_q != TX_IDLE);

endmodule
`default_nettype wire

// File: rtl/uart_tx_avalon.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_tx_avalon: Avalon-MM UART transmitter with TX FIFO. Rev 1.0
// ---------------------------------------------------------------------------
module uart_tx_avalon
  import uart_tx_avalon_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic        chipselect,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        TX_out
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int NW = $clog2(FIFO_DEPTH + 1);

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [NW-1:0]        count;
  logic                 empty, full, push, pop, busy;
  logic                 wr_txdata, wr_control, rd_en;
  logic                 parity_en, parity_odd, overflow;
  logic [31:0]          rd_mux;
  logic                 unused_writedata;

  assign empty      = (count == '0);
  assign full       = (count == NW'(FIFO_DEPTH));
  assign wr_txdata  = chipselect & write & (address == ADDR_TXDATA);
  assign wr_control = chipselect & write & (address == ADDR_CONTROL);
  assign rd_en      = chipselect & read;
  // A full FIFO still takes a byte when the core drains one in the same cycle.
  assign push       = wr_txdata & (!full | pop);
  assign unused_writedata = &{1'b0, writedata[31:DATA_BITS]};

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= writedata[DATA_BITS-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      parity_en  <= 1'b0;
      parity_odd <= 1'b0;
      readdata   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (wr_txdata && !push)
        overflow <= 1'b1;
      else if (wr_control && writedata[CTL_OVF_CLR])
        overflow <= 1'b0;
      if (wr_control) begin
        parity_en  <= writedata[CTL_PAR_EN];
        parity_odd <= writedata[CTL_PAR_ODD];
      end
      if (rd_en) readdata <= rd_mux;
    end
  end

  always_comb begin
    rd_mux = '0;
    if (address == ADDR_STATUS) begin
      rd_mux[ST_BUSY]          = busy;
      rd_mux[ST_EMPTY]         = empty;
      rd_mux[ST_FULL]          = full;
      rd_mux[ST_OVF]           = overflow;
      rd_mux[ST_CNT_LSB +: 4]  = 4'(count);
    end else if (address == ADDR_CONTROL) begin
      rd_mux[CTL_PAR_EN]  = parity_en;
      rd_mux[CTL_PAR_ODD] = parity_odd;
    end
  end

  uart_tx_core #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .DATA_BITS    (DATA_BITS)
  ) u_core (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (!empty),
    .data       (mem[rd_ptr]),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .tx         (TX_out),
    .busy       (busy),
    .pop        (pop)
  );

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_avalon.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_uart_tx_avalon: scoreboard bench for the Avalon UART transmitter. Rev 1.0
// ---------------------------------------------------------------------------
module tb_uart_tx_avalon;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        read = 1'b0, write = 1'b0, chipselect = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        TX_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_wr_cyc = 0;

  typedef struct {
    logic [10:0] bits;
    int          nbits;
  } frame_t;

  frame_t sb[$];
  int     starts[$];
  logic   mon_active = 1'b0;
  logic   cfg_par_en = 1'b0, cfg_par_odd = 1'b0;

  uart_tx_avalon #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (8),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .read       (read),
    .write      (write),
    .chipselect (chipselect),
    .writedata  (writedata),
    .readdata   (readdata),
    .TX_out     (TX_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic frame_t make_frame(input logic [7:0] d, input logic pen, input logic podd);
    frame_t f;
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    f.bits      = '0;
    f.bits[8:1] = d;
    if (pen) begin
      f.bits[9]  = ((ones % 2) == 1) ^ podd;
      f.bits[10] = 1'b1;
      f.nbits    = 11;
    end else begin
      f.bits[9]  = 1'b1;
      f.nbits    = 10;
    end
    return f;
  endfunction

  task automatic bus_cycle(input logic cs, input logic rd, input logic wr,
                           input logic [1:0] a, input logic [31:0] wd);
    @(posedge clk); #1;
    chipselect = cs; read = rd; write = wr; address = a; writedata = wd;
    last_wr_cyc = cyc;
    @(posedge clk); #1;
    chipselect = 1'b0; read = 1'b0; write = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] wd);
    bus_cycle(1'b1, 1'b0, 1'b1, a, wd);
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    bus_cycle(1'b1, 1'b1, 1'b0, a, 32'h0);
    d = readdata;
  endtask

  task automatic set_control(input logic [31:0] v);
    bus_write(2'd2, v);
    cfg_par_en  = v[0];
    cfg_par_odd = v[1];
  endtask

  task automatic tx_byte(input logic [7:0] d, input logic accept);
    if (accept) sb.push_back(make_frame(d, cfg_par_en, cfg_par_odd));
    bus_write(2'd0, {24'h0, d});
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((sb.size() != 0 || mon_active) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_value(tag, sb.size() + int'(mon_active), 0);
  endtask

  // Line monitor: every cycle of every bit must hold the expected level.
  initial begin : monitor
    frame_t      f;
    logic [10:0] got;
    logic        first, stable, aborted;
    forever begin
      @(negedge clk);
      if (reset_n && TX_out === 1'b0) begin
        mon_active = 1'b1;
        starts.push_back(cyc);
        check_value("frame_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) f = sb.pop_front();
        else begin f.bits = '0; f.nbits = 10; end
        got = '0; stable = 1'b1; aborted = 1'b0; first = 1'b0;
        for (int b = 0; b < f.nbits && !aborted; b++) begin
          for (int c = 0; c < CPB && !aborted; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (!reset_n) aborted = 1'b1;
            else if (c == 0) begin first = TX_out; got[b] = TX_out; end
            else if (TX_out !== first) stable = 1'b0;
          end
        end
        if (!aborted) begin
          check_value("frame_bits", 32'(got), 32'(f.bits));
          check_value("bit_width", 32'(stable), 32'd1);
          @(negedge clk);
          check_value("idle_turnaround", 32'(TX_out), 32'd1);
        end
        mon_active = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin : main
    logic [31:0] rd;
    int n0, s0, n;

    repeat (3) @(posedge clk);
    #1;
    check_value("reset_readdata", readdata, 32'h0);
    check_value("reset_tx", 32'(TX_out), 32'd1);
    @(negedge clk) reset_n = 1'b1;

    bus_read(2'd1, rd); check_value("status_reset", rd, 32'h02);
    bus_read(2'd2, rd); check_value("control_reset", rd, 32'h0);
    bus_read(2'd1, rd);
    bus_cycle(1'b0, 1'b0, 1'b1, 2'd0, 32'h99);
    bus_cycle(1'b0, 1'b1, 1'b0, 2'd2, 32'h0);
    check_value("cs0_readdata_hold", readdata, 32'h02);
    repeat (20) @(posedge clk);
    check_value("cs0_no_frame", starts.size(), 0);
    bus_read(2'd1, rd); check_value("cs0_fifo_empty", rd, 32'h02);

    tx_byte(8'h55, 1'b1);
    n0 = last_wr_cyc;
    repeat (10) @(posedge clk);
    bus_read(2'd1, rd); check_value("status_busy", rd, 32'h03);
    drain("drain_55");
    check_value("start_latency", starts[0] - n0, 2);
    bus_read(2'd1, rd); check_value("status_idle", rd, 32'h02);

    set_control(32'h1); tx_byte(8'h07, 1'b1); drain("drain_even");
    set_control(32'h3); tx_byte(8'h07, 1'b1); drain("drain_odd");
    bus_read(2'd2, rd); check_value("control_rb", rd, 32'h3);
    set_control(32'h0);

    n0 = starts.size();
    for (int i = 1; i <= 5; i++) tx_byte(8'(i), 1'b1);
    tx_byte(8'h06, 1'b0);
    bus_read(2'd1, rd); check_value("status_full_ovf", rd, 32'h4D);
    drain("drain_burst");
    for (int i = 1; i < 5; i++)
      check_value("b2b_gap", starts[n0 + i] - starts[n0 + i - 1], 10 * CPB + 1);
    bus_read(2'd1, rd); check_value("ovf_sticky", rd, 32'h0A);
    bus_write(2'd2, 32'h4);
    bus_read(2'd1, rd); check_value("ovf_cleared", rd, 32'h02);
    bus_read(2'd2, rd); check_value("ovf_clr_selfclear", rd, 32'h0);
    bus_write(2'd3, 32'hFF);
    bus_write(2'd1, 32'hFF);
    bus_read(2'd3, rd); check_value("reserved_zero", rd, 32'h0);
    bus_read(2'd1, rd); check_value("status_after_ignored", rd, 32'h02);

    n0 = starts.size();
    tx_byte(8'hA5, 1'b1);
    tx_byte(8'h11, 1'b1);
    tx_byte(8'h22, 1'b1);
    n = 0;
    while (starts.size() == n0 && n < 200) begin @(negedge clk); n++; end
    check_value("abort_frame_started", starts.size(), n0 + 1);
    if (starts.size() > n0) begin
      s0 = starts[n0];
      while (cyc < s0 + 17) @(negedge clk);
    end
    #1 reset_n = 1'b0;
    sb.delete();
    #1 check_value("reset_tx_high", 32'(TX_out), 32'd1);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    check_value("reset_readdata_mid", readdata, 32'h0);
    bus_read(2'd1, rd); check_value("status_after_abort", rd, 32'h02);
    repeat (200) @(posedge clk);
    check_value("no_frames_after_abort", starts.size(), n0 + 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
